// File: rtl/neighbor_sink_scan.sv
// Walks the neighbor/cluster tables, compares each neighbor ID against the sink list and
// writes an aggregation flag and match count. NSCAN_SINK_CACHE_EN keeps sinks after neighbor 0.
module neighbor_sink_scan #(
  parameter int unsigned           WORD_WIDTH = 16,
  parameter int unsigned           MAX_COUNT  = 32,
  parameter logic [WORD_WIDTH-1:0] ADDR_KSC   = 'h688,
  parameter logic [WORD_WIDTH-1:0] ADDR_NC    = 'h68A,
  parameter logic [WORD_WIDTH-1:0] ADDR_NID   = 'h48,
  parameter logic [WORD_WIDTH-1:0] ADDR_CID   = 'hC8,
  parameter logic [WORD_WIDTH-1:0] ADDR_SINK  = 'h8,
  parameter logic [WORD_WIDTH-1:0] ADDR_FLAG  = 'h2,
  parameter logic [WORD_WIDTH-1:0] ADDR_MCNT  = 'h4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  scan_all,
  input  logic [WORD_WIDTH-1:0] my_cluster_id,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  for_aggregation,
  output logic [WORD_WIDTH-1:0] match_count
);

  localparam int unsigned           IDX_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [WORD_WIDTH-1:0] MAX_W = WORD_WIDTH'(MAX_COUNT);
  localparam logic [WORD_WIDTH-1:0] ONE   = WORD_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, RD_KSC, RD_NC, RD_NID, RD_CID, CMP, WR_FLAG, WR_CNT, DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [WORD_WIDTH-1:0]   address_nxt, data_out_nxt, match_count_nxt;
  logic                    wr_en_nxt, busy_nxt, done_nxt, flag_nxt;
  logic [WORD_WIDTH-1:0]   k, k_nxt, n, n_nxt, i, i_nxt, j, j_nxt;
  logic [WORD_WIDTH-1:0]   nid, nid_nxt, cid, cid_nxt, my_id, my_id_nxt;
  logic                    all_q, all_nxt;
  logic [WORD_WIDTH-1:0]   clamped, hits, inc, cached_hits;
  logic [WORD_WIDTH:0]     sum;
  logic                    use_cache, last_sink, hit;

  assign clamped = (data_in > MAX_W) ? MAX_W : data_in;

`ifdef NSCAN_SINK_CACHE_EN
  logic [WORD_WIDTH-1:0] cache [MAX_COUNT];

  // Sinks seen while scanning neighbor 0 are reused for every later neighbor.
  always_ff @(posedge clock) begin
    if (state == CMP && i == '0) cache[IDX_W'(j)] <= data_in;
  end

  always_comb begin
    cached_hits = '0;
    for (int unsigned s = 0; s < MAX_COUNT; s++) begin
      if (WORD_WIDTH'(s) < k && cache[IDX_W'(s)] == nid) cached_hits = cached_hits + ONE;
    end
  end

  assign use_cache = (i != '0);
`else
  assign cached_hits = '0;
  assign use_cache   = 1'b0;
`endif

  assign hits      = use_cache ? cached_hits : ((data_in == nid) ? ONE : '0);
  assign last_sink = use_cache || (j == k - ONE);
  assign hit       = (hits != '0) && (cid != my_id);
  assign inc       = all_q ? hits : ONE;
  assign sum       = {1'b0, match_count} + {1'b0, inc};

  // Next-state and next-output logic; every register is loaded from its *_nxt value.
  always_comb begin
    state_nxt       = state;
    address_nxt     = address;
    wr_en_nxt       = 1'b0;
    data_out_nxt    = '0;
    flag_nxt        = for_aggregation;
    match_count_nxt = match_count;
    k_nxt           = k;
    n_nxt           = n;
    i_nxt           = i;
    j_nxt           = j;
    nid_nxt         = nid;
    cid_nxt         = cid;
    my_id_nxt       = my_id;
    all_nxt         = all_q;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt       = RD_KSC;
          address_nxt     = ADDR_KSC;
          flag_nxt        = 1'b0;
          match_count_nxt = '0;
          all_nxt         = scan_all;
          my_id_nxt       = my_cluster_id;
        end
      end
      RD_KSC: begin
        k_nxt       = clamped;
        address_nxt = ADDR_NC;
        state_nxt   = RD_NC;
      end
      RD_NC: begin
        n_nxt = clamped;
        if (clamped == '0 || k == '0) begin
          state_nxt = WR_FLAG;
        end else begin
          i_nxt       = '0;
          address_nxt = ADDR_NID;
          state_nxt   = RD_NID;
        end
      end
      RD_NID: begin
        nid_nxt     = data_in;
        address_nxt = ADDR_CID + (i << 1);
        state_nxt   = RD_CID;
      end
      RD_CID: begin
        cid_nxt     = data_in;
        j_nxt       = '0;
        address_nxt = ADDR_SINK;
        state_nxt   = CMP;
      end
      CMP: begin
        if (hit) begin
          flag_nxt        = 1'b1;
          match_count_nxt = sum[WORD_WIDTH] ? '1 : sum[WORD_WIDTH-1:0];
        end
        if (hit && !all_q) begin
          state_nxt = WR_FLAG;
        end else if (last_sink) begin
          if (i == n - ONE) begin
            state_nxt = WR_FLAG;
          end else begin
            i_nxt       = i + ONE;
            address_nxt = ADDR_NID + (i_nxt << 1);
            state_nxt   = RD_NID;
          end
        end else begin
          j_nxt       = j + ONE;
          address_nxt = ADDR_SINK + (j_nxt << 1);
        end
      end
      WR_FLAG: state_nxt = WR_CNT;
      WR_CNT:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Write strobes are registered, so they are set up on entry to the write states.
    if (state_nxt == WR_FLAG) begin
      address_nxt  = ADDR_FLAG;
      wr_en_nxt    = 1'b1;
      data_out_nxt = WORD_WIDTH'(flag_nxt);
    end
    if (state_nxt == WR_CNT) begin
      address_nxt  = ADDR_MCNT;
      wr_en_nxt    = 1'b1;
      data_out_nxt = match_count_nxt;
    end
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state           <= IDLE;
      address         <= ADDR_KSC;
      wr_en           <= 1'b0;
      data_out        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      for_aggregation <= 1'b0;
      match_count     <= '0;
      k               <= '0;
      n               <= '0;
      i               <= '0;
      j               <= '0;
      nid             <= '0;
      cid             <= '0;
      my_id           <= '0;
      all_q           <= 1'b0;
    end else begin
      state           <= state_nxt;
      address         <= address_nxt;
      wr_en           <= wr_en_nxt;
      data_out        <= data_out_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      for_aggregation <= flag_nxt;
      match_count     <= match_count_nxt;
      k               <= k_nxt;
      n               <= n_nxt;
      i               <= i_nxt;
      j               <= j_nxt;
      nid             <= nid_nxt;
      cid             <= cid_nxt;
      my_id           <= my_id_nxt;
      all_q           <= all_nxt;
    end
  end

endmodule

// File: tb/tb_neighbor_sink_scan.sv
// Self-checking bench: a table-walking reference model predicts the per-cycle bus trace of
// every scan, and one negedge process compares the DUT against that trace.
module tb_neighbor_sink_scan;

  localparam int          MAXC   = 32;
  localparam logic [15:0] A_KSC  = 16'h688;
  localparam logic [15:0] A_NC   = 16'h68A;
  localparam logic [15:0] A_NID  = 16'h48;
  localparam logic [15:0] A_CID  = 16'hC8;
  localparam logic [15:0] A_SINK = 16'h8;
  localparam logic [15:0] A_FLAG = 16'h2;
  localparam logic [15:0] A_MCNT = 16'h4;
`ifdef NSCAN_SINK_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  typedef struct {
    bit          chk_addr;
    logic [15:0] addr;
    bit          wr;
    bit          chk_dout;
    logic [15:0] dout;
    bit          done;
    bit          busy;
    bit          chk_res;
    bit          flag;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        scan_all;
  logic [15:0] my_cluster_id;
  logic [15:0] data_in;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic        busy;
  logic        done;
  logic        for_aggregation;
  logic [15:0] match_count;

  logic [15:0] mem [0:2047];
  exp_t        exp_q [$];
  exp_t        trace [$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;

  neighbor_sink_scan dut (
    .clock          (clk),
    .rst            (rst),
    .start          (start),
    .scan_all       (scan_all),
    .my_cluster_id  (my_cluster_id),
    .data_in        (data_in),
    .address        (address),
    .wr_en          (wr_en),
    .data_out       (data_out),
    .busy           (busy),
    .done           (done),
    .for_aggregation(for_aggregation),
    .match_count    (match_count)
  );

  // Memory answers the registered address in the same cycle it is presented.
  assign data_in = mem[address[11:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t mk(input bit ca, input logic [15:0] a, input bit wr, input bit cd,
                              input logic [15:0] d, input bit dn, input bit bz);
    exp_t e;
    e.chk_addr = ca; e.addr = a; e.wr = wr; e.chk_dout = cd; e.dout = d;
    e.done = dn; e.busy = bz; e.chk_res = 1'b0; e.flag = 1'b0; e.cnt = '0;
    return e;
  endfunction

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem[a[11:1]];
  endfunction

  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    mem[a[11:1]] = v;
  endtask

  // Reference: walk the tables as the scan rules describe and list what each cycle must show.
  function automatic void build(input bit all, input logic [15:0] my,
                                output int lat, output int cnt, output bit flag);
    int          k, n;
    logic [15:0] nid, cid;
    bit          stop;
    exp_t        e;
    trace.delete();
    k = int'(rd(A_KSC)); if (k > MAXC) k = MAXC;
    n = int'(rd(A_NC));  if (n > MAXC) n = MAXC;
    cnt = 0; flag = 1'b0; stop = 1'b0;
    e = mk(1'b1, A_KSC, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    e.chk_res = 1'b1;
    trace.push_back(e);
    trace.push_back(mk(1'b1, A_NC, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1));
    if (n > 0 && k > 0) begin
      for (int i = 0; i < n && !stop; i++) begin
        nid = rd(A_NID + 16'(2 * i));
        cid = rd(A_CID + 16'(2 * i));
        trace.push_back(mk(1'b1, A_NID + 16'(2 * i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b1));
        trace.push_back(mk(1'b1, A_CID + 16'(2 * i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b1));
        if (CACHE && i > 0) begin
          int m;
          m = 0;
          for (int s = 0; s < k; s++) if (rd(A_SINK + 16'(2 * s)) == nid) m++;
          trace.push_back(mk(1'b0, A_SINK, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1));
          if (m > 0 && cid != my) begin
            flag = 1'b1;
            cnt += all ? m : 1;
            if (!all) stop = 1'b1;
          end
        end else begin
          for (int s = 0; s < k && !stop; s++) begin
            trace.push_back(mk(1'b1, A_SINK + 16'(2 * s), 1'b0, 1'b0, 16'h0, 1'b0, 1'b1));
            if (rd(A_SINK + 16'(2 * s)) == nid && cid != my) begin
              flag = 1'b1;
              cnt++;
              if (!all) stop = 1'b1;
            end
          end
        end
      end
    end
    trace.push_back(mk(1'b1, A_FLAG, 1'b1, 1'b1, 16'(flag), 1'b0, 1'b1));
    trace.push_back(mk(1'b1, A_MCNT, 1'b1, 1'b1, 16'(cnt), 1'b0, 1'b1));
    e = mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    e.chk_res = 1'b1; e.flag = flag; e.cnt = 16'(cnt);
    trace.push_back(e);
    lat = trace.size();
    e = mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    e.chk_res = 1'b1; e.flag = flag; e.cnt = 16'(cnt);
    trace.push_back(e);
  endfunction

  // Single compare process: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("busy", 32'(busy), 32'(cur.busy));
      chk("done", 32'(done), 32'(cur.done));
      chk("wr_en", 32'(wr_en), 32'(cur.wr));
      if (cur.chk_addr) chk("address", 32'(address), 32'(cur.addr));
      if (cur.chk_dout) chk("data_out", 32'(data_out), 32'(cur.dout));
      if (cur.chk_res) begin
        chk("for_aggregation", 32'(for_aggregation), 32'(cur.flag));
        chk("match_count", 32'(match_count), 32'(cur.cnt));
      end
    end
  end

  task automatic wait_drain();
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending expectations, expected 0", exp_q.size());
    exp_q.delete();
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e = mk(1'b1, A_KSC, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    e.chk_res = 1'b1;
    return e;
  endfunction

  // Pulse start, queue the predicted trace; cut>0 keeps only the first cut cycles.
  task automatic launch(input bit all, input logic [15:0] my, input int cut,
                        output int lat, output int cnt, output bit flag);
    @(negedge clk); #1;
    start = 1'b1; scan_all = all; my_cluster_id = my;
    build(all, my, lat, cnt, flag);
    @(posedge clk); #1;
    start = 1'b0;
    scan_all = 1'($urandom_range(0, 1));
    my_cluster_id = 16'($urandom_range(0, 2));
    foreach (trace[x]) if (cut == 0 || x < cut) exp_q.push_back(trace[x]);
  endtask

  task automatic run(input bit all, input logic [15:0] my, input bit poke,
                     output int lat, output int cnt, output bit flag);
    launch(all, my, 0, lat, cnt, flag);
    if (poke) begin
      int c;
      c = $urandom_range(1, lat - 1);
      repeat (c) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
    end
    wait_drain();
  endtask

  task automatic load_basic(input logic [15:0] n0, input logic [15:0] n1,
                            input logic [15:0] c0, input logic [15:0] c1);
    wr(A_KSC, 16'd3); wr(A_NC, 16'd2);
    wr(A_NID, n0); wr(A_NID + 16'd2, n1);
    wr(A_CID, c0); wr(A_CID + 16'd2, c1);
    wr(A_SINK, 16'd7); wr(A_SINK + 16'd2, 16'd9); wr(A_SINK + 16'd4, 16'd3);
  endtask

  initial begin
    int lat, cnt;
    bit flag;
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0;
    rst = 1'b1; start = 1'b1; scan_all = 1'b0; my_cluster_id = 16'h0;

    // Reset state, with start held high to show reset wins.
    repeat (2) @(negedge clk);
    #1 exp_q.push_back(reset_exp());
    wait_drain();
    start = 1'b0; rst = 1'b0;

    // Full scan: only neighbor 1 (cluster 2) hits sink 9.
    load_basic(16'd5, 16'd9, 16'd1, 16'd2);
    run(1'b1, 16'd1, 1'b0, lat, cnt, flag);
    chk("lat_full", 32'(lat), CACHE ? 32'd13 : 32'd15);
    chk("cnt_full", 32'(cnt), 32'd1);
    chk("flag_full", 32'(flag), 32'd1);

    // First-match mode stops at neighbor 0 sink 1.
    load_basic(16'd9, 16'd5, 16'd2, 16'd1);
    run(1'b0, 16'd1, 1'b0, lat, cnt, flag);
    chk("lat_first", 32'(lat), 32'd9);
    chk("cnt_first", 32'(cnt), 32'd1);

    // No neighbors: straight to the writes.
    wr(A_KSC, 16'd4); wr(A_NC, 16'd0);
    run(1'b1, 16'd1, 1'b0, lat, cnt, flag);
    chk("lat_empty", 32'(lat), 32'd5);
    chk("cnt_empty", 32'(cnt), 32'd0);

    // Every hit lies in the own cluster.
    load_basic(16'd7, 16'd3, 16'd1, 16'd1);
    run(1'b1, 16'd1, 1'b0, lat, cnt, flag);
    chk("cnt_own", 32'(cnt), 32'd0);
    chk("flag_own", 32'(flag), 32'd0);

    // Reset during WR_FLAG, then a clean scan.
    load_basic(16'd5, 16'd9, 16'd1, 16'd2);
    launch(1'b1, 16'd1, CACHE ? 11 : 13, lat, cnt, flag);
    wait_drain();
    rst = 1'b1;
    exp_q.push_back(reset_exp());
    wait_drain();
    rst = 1'b0;
    run(1'b1, 16'd1, 1'b0, lat, cnt, flag);
    chk("cnt_after_rst", 32'(cnt), 32'd1);

    // Oversized K is clamped to 32 sinks; stray start while busy.
    wr(A_KSC, 16'd40); wr(A_NC, 16'd2);
    for (int s = 0; s < MAXC; s++) wr(A_SINK + 16'(2 * s), 16'(s % 4));
    wr(A_NID, 16'd1); wr(A_NID + 16'd2, 16'd2);
    wr(A_CID, 16'd5); wr(A_CID + 16'd2, 16'd6);
    run(1'b1, 16'd0, 1'b1, lat, cnt, flag);
    chk("lat_clamp", 32'(lat), CACHE ? 32'd42 : 32'd73);
    chk("cnt_clamp", 32'(cnt), 32'd16);

    // Randomized tables and modes.
    for (int r = 0; r < 30; r++) begin
      int kr, nr;
      kr = $urandom_range(0, 6);
      nr = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) kr = $urandom_range(33, 45);
      if ($urandom_range(0, 9) == 0) nr = $urandom_range(33, 40);
      wr(A_KSC, 16'(kr)); wr(A_NC, 16'(nr));
      for (int x = 0; x < MAXC; x++) begin
        wr(A_NID + 16'(2 * x), 16'($urandom_range(0, 3)));
        wr(A_CID + 16'(2 * x), 16'($urandom_range(0, 2)));
        wr(A_SINK + 16'(2 * x), 16'($urandom_range(0, 3)));
      end
      run(1'($urandom_range(0, 1)), 16'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
          lat, cnt, flag);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
